// File: rtl/mspeckey_iter_core.sv
// Iterative mini-SPECKEY round core: one keyless round per clock, valid/ready on both sides.
// Optional macro MSPECKEY_ENC_EN adds the mode_enc port and the inverse (encryption) round.
module mspeckey_iter_core #(
  parameter int unsigned WORD_W = 8,
  parameter int unsigned ROUNDS = 2,
  parameter int unsigned ALPHA  = 1,
  parameter int unsigned BETA   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [2*WORD_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*WORD_W-1:0] out_data,
`ifdef MSPECKEY_ENC_EN
  input  logic                mode_enc,
`endif
  output logic                busy
);

  localparam int unsigned CNT_W = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [2*WORD_W-1:0] st;
  logic [2*WORD_W-1:0] round_out;
  logic                accept;

  function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

  function automatic logic [2*WORD_W-1:0] dec_round(input logic [2*WORD_W-1:0] s);
    logic [WORD_W-1:0] h, l, t, lo, diff;
    h    = s[2*WORD_W-1:WORD_W];
    l    = s[WORD_W-1:0];
    t    = h ^ l;
    lo   = ror(t, BETA);
    diff = h - lo;
    return {ror(diff, ALPHA), lo};
  endfunction

`ifdef MSPECKEY_ENC_EN
  logic mode_q;

  function automatic logic [2*WORD_W-1:0] enc_round(input logic [2*WORD_W-1:0] s);
    logic [WORD_W-1:0] hh, ll, hi, lo;
    hh = s[2*WORD_W-1:WORD_W];
    ll = s[WORD_W-1:0];
    hi = rol(hh, ALPHA) + ll;
    lo = rol(ll, BETA) ^ hi;
    return {hi, lo};
  endfunction

  always_comb begin
    round_out = mode_q ? enc_round(st) : dec_round(st);
  end
`else
  always_comb begin
    round_out = dec_round(st);
  end
`endif

  // in_ready looks through to out_ready in DONE so a waiting block can follow back-to-back
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == RUN);
  assign out_data  = st;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      st    <= '0;
`ifdef MSPECKEY_ENC_EN
      mode_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (accept) begin
            st    <= in_data;
            cnt   <= '0;
            state <= RUN;
`ifdef MSPECKEY_ENC_EN
            mode_q <= mode_enc;
`endif
          end else if (state == DONE && out_ready) begin
            state <= IDLE;
          end
        end
        RUN: begin
          st  <= round_out;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ROUNDS - 1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mspeckey_iter_core.sv
// Directed bench for mspeckey_iter_core: default build plus a ROUNDS=1 instance.
// Encryption checks compile in only when MSPECKEY_ENC_EN is defined.
module tb_mspeckey_iter_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_data, out_data;
  logic        in_valid_1, in_ready_1, out_valid_1, out_ready_1, busy_1;
  logic [15:0] in_data_1, out_data_1;
`ifdef MSPECKEY_ENC_EN
  logic        mode_enc = 1'b0;
  logic        mode_enc_1 = 1'b0;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] vecs [10] = '{16'h1234, 16'h0000, 16'hFFFF, 16'hA5C3, 16'h0001,
                             16'h8000, 16'h7E81, 16'hDEAD, 16'hBEEF, 16'h55AA};

  mspeckey_iter_core dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data),
`ifdef MSPECKEY_ENC_EN
    .mode_enc(mode_enc),
`endif
    .busy(busy)
  );

  mspeckey_iter_core #(.ROUNDS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_1), .in_ready(in_ready_1),
    .in_data(in_data_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
    .out_data(out_data_1),
`ifdef MSPECKEY_ENC_EN
    .mode_enc(mode_enc_1),
`endif
    .busy(busy_1)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ror8(input logic [7:0] x, input int n);
    logic [15:0] d;
    d = {x, x} >> n;
    return d[7:0];
  endfunction

  // Reference decryption: WORD_W=8, ALPHA=1, BETA=2
  function automatic logic [15:0] model_dec(input logic [15:0] s, input int rounds);
    logic [7:0] h, l, t, d;
    h = s[15:8];
    l = s[7:0];
    for (int r = 0; r < rounds; r++) begin
      t = ror8(h ^ l, 2);
      d = h - t;
      h = ror8(d, 1);
      l = t;
    end
    return {h, l};
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b1;
    in_valid_1 = 1'b0; in_data_1 = 16'h0; out_ready_1 = 1'b1;
    #2;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
    n_cmp++; if (out_valid_1 !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid_r1: got %b want 0", out_valid_1); end
    n_cmp++; if (out_data_1 !== 16'h0000) begin n_bad++; $display("FAIL reset_out_data_r1: got %h want 0000", out_data_1); end
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (in_ready_1 !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready_r1: got %b want 1", in_ready_1); end
  endtask

  task automatic test_basic;
    in_data = 16'h1234; in_valid = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0; in_data = 16'hFFFF;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy1: got %b want 1", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid1: got %b want 0", out_valid); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid2: got %b want 0", out_valid); end
    tick;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid3: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'hB853) begin n_bad++; $display("FAIL basic_data: got %h want b853", out_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_busy3: got %b want 0", busy); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid4: got %b want 0", out_valid); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready4: got %b want 1", in_ready); end
  endtask

  task automatic test_rounds1;
    in_data_1 = 16'h1234; in_valid_1 = 1'b1;
    tick;
    in_valid_1 = 1'b0;
    n_cmp++; if (busy_1 !== 1'b1) begin n_bad++; $display("FAIL r1_busy: got %b want 1", busy_1); end
    tick;
    n_cmp++; if (out_valid_1 !== 1'b1) begin n_bad++; $display("FAIL r1_valid: got %b want 1", out_valid_1); end
    n_cmp++; if (out_data_1 !== 16'hC489) begin n_bad++; $display("FAIL r1_data_1234: got %h want c489", out_data_1); end
    tick;
    in_data_1 = 16'h0000; in_valid_1 = 1'b1;
    tick;
    in_valid_1 = 1'b0;
    tick;
    n_cmp++; if (out_valid_1 !== 1'b1) begin n_bad++; $display("FAIL r1_valid_zero: got %b want 1", out_valid_1); end
    n_cmp++; if (out_data_1 !== 16'h0000) begin n_bad++; $display("FAIL r1_data_zero: got %h want 0000", out_data_1); end
    tick;
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0; in_data = 16'h1234; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    tick;
    tick;
    in_valid = 1'b1; in_data = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); end
      n_cmp++; if (out_data !== 16'hB853) begin n_bad++; $display("FAIL bp_data[%0d]: got %h want b853", i, out_data); end
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_busy[%0d]: got %b want 0", i, busy); end
      tick;
    end
    in_data = 16'h0000; out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
    tick;
    in_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL bp_reaccept_busy: got %b want 1", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_reaccept_valid: got %b want 0", out_valid); end
    tick;
    tick;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
    n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL bp_next_data: got %h want 0000", out_data); end
    tick;
  endtask

  task automatic test_reset_mid_run;
    out_ready = 1'b1; in_data = 16'h1234; in_valid = 1'b1;
    tick;
    in_valid = 1'b0;
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0000) begin n_bad++; $display("FAIL rst_mid_data: got %h want 0000", out_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_stale_valid[%0d]: got %b want 0", i, out_valid); end
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready[%0d]: got %b want 1", i, in_ready); end
    end
  endtask

  task automatic test_back_to_back;
    int sent;
    int got;
    int last_cyc;
    logic acc;
    sent = 0; got = 0; last_cyc = -1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = vecs[0];
    for (int cyc = 0; cyc < 60; cyc++) begin
      acc = in_valid && in_ready;
      tick;
      if (acc) begin
        sent++;
        if (sent < 10) in_data = vecs[sent];
        else begin in_valid = 1'b0; in_data = 16'h0; end
      end
      if (out_valid) begin
        if (got < 10) begin
          n_cmp++; if (out_data !== model_dec(vecs[got], 2)) begin n_bad++; $display("FAIL stream_data[%0d]: got %h want %h", got, out_data, model_dec(vecs[got], 2)); end
        end else begin
          n_cmp++; n_bad++; $display("FAIL stream_extra: got result %h want none", out_data);
        end
        if (got > 0) begin
          n_cmp++; if (cyc - last_cyc != 3) begin n_bad++; $display("FAIL stream_gap[%0d]: got %0d want 3", got, cyc - last_cyc); end
        end
        last_cyc = cyc;
        got++;
      end
    end
    n_cmp++; if (got != 10) begin n_bad++; $display("FAIL stream_count: got %0d want 10", got); end
  endtask

`ifdef MSPECKEY_ENC_EN
  task automatic run_block(input logic enc, input logic [15:0] x, output logic [15:0] y, output logic ok);
    y = 16'h0; ok = 1'b0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = x; mode_enc = enc;
    tick;
    in_valid = 1'b0; mode_enc = ~enc;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (out_valid) begin ok = 1'b1; y = out_data; end
      else tick;
    end
    tick;
  endtask

  task automatic test_encrypt;
    logic [15:0] x, y, z;
    logic ok1, ok2;
    mode_enc_1 = 1'b1; in_data_1 = 16'hC489; in_valid_1 = 1'b1;
    tick;
    in_valid_1 = 1'b0; mode_enc_1 = 1'b0;
    tick;
    n_cmp++; if (out_valid_1 !== 1'b1) begin n_bad++; $display("FAIL enc_r1_valid: got %b want 1", out_valid_1); end
    n_cmp++; if (out_data_1 !== 16'h1234) begin n_bad++; $display("FAIL enc_r1_data: got %h want 1234", out_data_1); end
    tick;
    for (int i = 0; i < 6; i++) begin
      x = 16'($urandom);
      run_block(1'b1, x, y, ok1);
      run_block(1'b0, y, z, ok2);
      n_cmp++; if (!(ok1 && ok2)) begin n_bad++; $display("FAIL enc_rt_timeout[%0d]: got ok %b%b want 11", i, ok1, ok2); end
      n_cmp++; if (z !== x) begin n_bad++; $display("FAIL enc_roundtrip[%0d]: got %h want %h", i, z, x); end
    end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_rounds1;
    test_backpressure;
    test_reset_mid_run;
    test_back_to_back;
`ifdef MSPECKEY_ENC_EN
    test_encrypt;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
